// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if -- signal bundle between a requester (CPU load/store
// stage), the mem_access_unit, and the data memory it drives.
//   Request side : start, mem_write, data_type, funct3, addr, wdata
//   Status side  : busy, done, err, rdata
//   Memory side  : mem_req, mem_we, mem_addr, mem_be, mem_wdata,
//                  mem_ack, mem_rdata
// The slave modport is the unit itself; master is everything around it.
interface mem_access_unit_if;
   logic        start;
   logic        mem_write;
   logic [1:0]  data_type;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  start, mem_write, data_type, funct3, addr, wdata, mem_ack, mem_rdata,
      output busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output start, mem_write, data_type, funct3, addr, wdata, mem_ack, mem_rdata,
      input  busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit -- single-outstanding load/store unit between a RISC-V style
// execute stage and a word-wide data memory with a req/ack handshake.
//   clk  : sole clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : mem_access_unit_if.slave (request, status and memory signals)
// Parameter ACK_TIMEOUT (2..255): REQ cycles to wait for mem_ack before
// giving up with err.
// Flow: IDLE --start--> REQ --ack/timeout--> DONE --> IDLE, or
//       IDLE --start(illegal/misaligned)--> DONE (err) --> IDLE.
module mem_access_unit #(
   parameter int ACK_TIMEOUT = 16
) (
   input logic              clk,
   input logic              rst,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   // Last REQ cycle index before timeout (counter starts at 0 on entry).
   localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [31:0] mem_addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [7:0]  cnt;

   logic        legal, aligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [31:0] shifted, load_val;
   logic        timeout;

   // ---- request decode (only meaningful while IDLE) ----
   always_comb begin
      legal = 1'b0;
      case (bus.data_type)
         2'b00: legal = (bus.funct3 == 3'b010);
         2'b01: begin
            case (bus.funct3)
               3'b000, 3'b001: legal = 1'b1;
               3'b100, 3'b101: legal = !bus.mem_write;   // BU/HU are load-only
               default:        legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase

      // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word
      case (bus.funct3[1:0])
         2'b10:   aligned = (bus.addr[1:0] == 2'b00);
         2'b01:   aligned = !bus.addr[0];
         default: aligned = 1'b1;
      endcase

      case (bus.funct3[1:0])
         2'b10: begin
            be_new    = 4'b1111;
            wdata_new = bus.wdata;
         end
         2'b01: begin
            be_new    = bus.addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{bus.wdata[15:0]}};
         end
         default: begin
            be_new    = 4'b0001 << bus.addr[1:0];
            wdata_new = {4{bus.wdata[7:0]}};
         end
      endcase
   end

   // ---- load extraction: move the addressed lane to bit 0, then extend ----
   always_comb begin
      shifted = bus.mem_rdata >> {off_q, 3'b000};
      case (f3_q[1:0])
         2'b00:   load_val = {{24{!f3_q[2] & shifted[7]}},  shifted[7:0]};
         2'b01:   load_val = {{16{!f3_q[2] & shifted[15]}}, shifted[15:0]};
         default: load_val = bus.mem_rdata;
      endcase
   end

   // Ack wins over timeout in the final cycle.
   assign timeout = !bus.mem_ack && (cnt == TO_LAST);

   // ---- FSM ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start) state_nxt = (legal && aligned) ? REQ : DONE;
         REQ:  if (bus.mem_ack || timeout) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- datapath registers ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         off_q      <= 2'b00;
         mem_addr_q <= 32'h0;
         be_q       <= 4'b0000;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         err_q      <= 1'b0;
         cnt        <= 8'h0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (legal && aligned) begin
                     we_q       <= bus.mem_write;
                     f3_q       <= bus.funct3;
                     off_q      <= bus.addr[1:0];
                     mem_addr_q <= {bus.addr[31:2], 2'b00};
                     be_q       <= be_new;
                     wdata_q    <= wdata_new;
                     err_q      <= 1'b0;
                     cnt        <= 8'h0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (bus.mem_ack) begin
                  err_q <= 1'b0;
                  if (!we_q) rdata_q <= load_val;
               end else if (timeout) begin
                  err_q <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Request-phase outputs decode straight from state so an async reset
   // drops mem_req/mem_we/mem_be without waiting for an edge.
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.err       = (state == DONE) && err_q;
   assign bus.mem_req   = (state == REQ);
   assign bus.mem_we    = (state == REQ) && we_q;
   assign bus.mem_be    = (state == REQ) ? be_q : 4'b0000;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.rdata     = rdata_q;

endmodule
